// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M multiply/divide unit for the execute stage.
//
// Takes one M-extension op at a time straight from the ID/EX register,
// requests a pipeline stall while it iterates (one shift-add or restoring
// divide step per cycle), and presents a registered result plus its
// writeback address for exactly one cycle.
//
// Ports:
//   clk, rst        core clock, asynchronous active-low reset
//   md_start        EX holds a valid M op this cycle
//   md_op           RV32M funct3 (MUL..REMU)
//   md_reg1/2       rs1 / rs2 operands
//   md_wd, md_wreg  destination address and write enable of the op
//   md_flush        abort any in-flight op (wins over md_start)
//   stall_req       hold IF, ID and ID/EX
//   md_done         result valid this cycle
//   md_result       result (holds last value outside md_done)
//   md_wd_o         destination address of the retiring op
//   md_wreg_o       write enable of the retiring op (qualify with md_done)
module ex_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            md_start,
  input  logic [2:0]      md_op,
  input  logic [XLEN-1:0] md_reg1,
  input  logic [XLEN-1:0] md_reg2,
  input  logic [4:0]      md_wd,
  input  logic            md_wreg,
  input  logic            md_flush,
  output logic            stall_req,
  output logic            md_done,
  output logic [XLEN-1:0] md_result,
  output logic [4:0]      md_wd_o,
  output logic            md_wreg_o
);

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state_q;
  logic [4:0]        cnt_q;
  md_op_e            op_q;
  logic [4:0]        wd_q;
  logic              wreg_q;
  logic              neg_q;      // product / quotient must be negated
  logic              rem_neg_q;  // remainder takes the dividend's sign
  logic [XLEN-1:0]   a_q;        // multiplicand magnitude
  logic [XLEN-1:0]   b_q;        // divisor magnitude
  logic [2*XLEN-1:0] acc_q;      // {partial product high, multiplier bits}
  logic [XLEN-1:0]   quot_q;     // dividend bits shifting out, quotient in
  logic [XLEN-1:0]   rem_q;

  // ---------------- operand decode in IDLE ----------------
  md_op_e          op_in;
  logic            sgn1_in, sgn2_in, neg1_in, neg2_in;
  logic [XLEN-1:0] abs1_in, abs2_in;
  logic            div_zero_in, div_ovf_in, fast_in;
  logic [XLEN-1:0] fast_res_in;

  always_comb begin
    op_in       = md_op_e'(md_op);
    // MUL is treated as signed; its low half is sign-agnostic anyway.
    sgn1_in     = (op_in == OP_MUL) || (op_in == OP_MULH) || (op_in == OP_MULHSU) ||
                  (op_in == OP_DIV) || (op_in == OP_REM);
    sgn2_in     = (op_in == OP_MUL) || (op_in == OP_MULH) ||
                  (op_in == OP_DIV) || (op_in == OP_REM);
    neg1_in     = sgn1_in & md_reg1[XLEN-1];
    neg2_in     = sgn2_in & md_reg2[XLEN-1];
    abs1_in     = neg1_in ? -md_reg1 : md_reg1;
    abs2_in     = neg2_in ? -md_reg2 : md_reg2;
    div_zero_in = md_op[2] && (md_reg2 == '0);
    div_ovf_in  = md_op[2] && !md_op[0] && (md_reg1 == INT_MIN) && (md_reg2 == '1);
    fast_in     = div_zero_in | div_ovf_in;
    // md_op[1] separates REM/REMU from DIV/DIVU.
    if (div_zero_in) fast_res_in = md_op[1] ? md_reg1 : '1;
    else             fast_res_in = md_op[1] ? '0 : INT_MIN;
  end

  // ---------------- one iteration step in BUSY ----------------
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] acc_step;
  logic [XLEN:0]     div_shift;  // 33-bit partial remainder after shift
  logic              div_ge;
  logic [XLEN-1:0]   div_diff, rem_step, quot_step;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix, final_res;

  always_comb begin
    // Right-shifting product register: add multiplicand into the high half
    // when the current multiplier LSB is set, carry lands in the MSB.
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : '0);
    acc_step  = {mul_sum, acc_q[XLEN-1:1]};
    div_shift = {rem_q, quot_q[XLEN-1]};
    div_ge    = div_shift >= {1'b0, b_q};
    // When div_ge holds the difference is below the divisor, so XLEN bits suffice.
    div_diff  = div_shift[XLEN-1:0] - b_q;
    rem_step  = div_ge ? div_diff : div_shift[XLEN-1:0];
    quot_step = {quot_q[XLEN-2:0], div_ge};

    prod_fix  = neg_q ? -acc_step : acc_step;
    quot_fix  = neg_q ? -quot_step : quot_step;
    rem_fix   = rem_neg_q ? -rem_step : rem_step;
    case (op_q)
      OP_MUL:                      final_res = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:             final_res = quot_fix;
      default:                     final_res = rem_fix;
    endcase
  end

  // Decoded from registered state plus the live start/flush inputs so the
  // pipeline freezes in the very cycle the op is accepted.
  assign stall_req = ((state_q == IDLE) && md_start && !md_flush) || (state_q == BUSY);

  // NOTE: every register here uses <= so all updates see pre-edge values;
  // datapath registers are reset as well so no X ever reaches md_result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= OP_MUL;
      wd_q      <= '0;
      wreg_q    <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      quot_q    <= '0;
      rem_q     <= '0;
      md_done   <= 1'b0;
      md_result <= '0;
      md_wd_o   <= '0;
      md_wreg_o <= 1'b0;
    end else if (md_flush) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      md_done <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          md_done <= 1'b0;
          if (md_start) begin
            op_q      <= op_in;
            wd_q      <= md_wd;
            wreg_q    <= md_wreg;
            neg_q     <= neg1_in ^ neg2_in;
            rem_neg_q <= neg1_in;
            a_q       <= abs1_in;
            b_q       <= abs2_in;
            acc_q     <= {{XLEN{1'b0}}, abs2_in};
            quot_q    <= abs1_in;
            rem_q     <= '0;
            cnt_q     <= '0;
            if (fast_in) begin
              state_q   <= DONE;
              md_done   <= 1'b1;
              md_result <= fast_res_in;
              md_wd_o   <= md_wd;
              md_wreg_o <= md_wreg;
            end else begin
              state_q <= BUSY;
            end
          end
        end
        BUSY: begin
          acc_q  <= acc_step;
          quot_q <= quot_step;
          rem_q  <= rem_step;
          cnt_q  <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_q   <= DONE;
            md_done   <= 1'b1;
            md_result <= final_res;
            md_wd_o   <= wd_q;
            md_wreg_o <= wreg_q;
          end
        end
        default: begin
          // DONE: the retiring op is still visible at the inputs, so start is ignored.
          md_done <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: self-checking bench for ex_muldiv. Directed table of RV32M
// corner cases, hand-written flush/reset sequences, and random ops checked
// against an arithmetic reference model.
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst;
  logic        md_start, md_flush, md_wreg;
  logic [2:0]  md_op;
  logic [31:0] md_reg1, md_reg2;
  logic [4:0]  md_wd;
  logic        stall_req, md_done, md_wreg_o;
  logic [31:0] md_result;
  logic [4:0]  md_wd_o;

  int checks   = 0;
  int failures = 0;

  ex_muldiv dut (
    .clk       (clk),
    .rst       (rst),
    .md_start  (md_start),
    .md_op     (md_op),
    .md_reg1   (md_reg1),
    .md_reg2   (md_reg2),
    .md_wd     (md_wd),
    .md_wreg   (md_wreg),
    .md_flush  (md_flush),
    .stall_req (stall_req),
    .md_done   (md_done),
    .md_result (md_result),
    .md_wd_o   (md_wd_o),
    .md_wreg_o (md_wreg_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h expected=0x%08h", name, got, exp);
    end
  endtask

  // Reference model: RV32M semantics with plain arithmetic.
  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint      sa, sb, ub;
    logic [63:0] p;
    int          ia, ib;
    ia = int'(a);
    ib = int'(b);
    sa = longint'(ia);
    sb = longint'(ib);
    ub = longint'({32'd0, b});
    case (op)
      3'b000: begin p = sa * sb; return p[31:0]; end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * ub; return p[63:32]; end
      3'b011: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(ia / ib);
      end
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(ia % ib);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    if (op[2] && b == 0) return 1;
    if ((op == 3'b100 || op == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Issue one op at a negedge, release start one cycle later (scrambling the
  // operand inputs to prove they were latched), and watch until md_done.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] wd, input logic wreg,
                        input logic [31:0] exp_res, input int exp_lat);
    int          stalls, lat;
    logic [31:0] res;
    logic [4:0]  wdo;
    logic        wro;
    @(negedge clk);
    md_start = 1'b1; md_op = op; md_reg1 = a; md_reg2 = b; md_wd = wd; md_wreg = wreg;
    #1;
    stalls = int'(stall_req);
    lat = 0; res = 'x; wdo = 'x; wro = 1'bx;
    for (int c = 1; c <= 40 && lat == 0; c++) begin
      @(negedge clk);
      md_start = 1'b0;
      md_reg1 = $urandom; md_reg2 = $urandom; md_wd = 5'($urandom); md_wreg = 1'($urandom);
      #1;
      if (md_done) begin
        lat = c; res = md_result; wdo = md_wd_o; wro = md_wreg_o;
      end else if (stall_req) begin
        stalls++;
      end
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " stall_cycles"}, 32'(stalls), 32'(exp_lat));
    check({tag, " result"}, res, exp_res);
    check({tag, " wd_o"}, {27'd0, wdo}, {27'd0, wd});
    check({tag, " wreg_o"}, {31'd0, wro}, {31'd0, wreg});
  endtask

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [31:0] exp_res;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int          seen;
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    rst = 1'b0; md_start = 1'b0; md_flush = 1'b0; md_op = '0;
    md_reg1 = '0; md_reg2 = '0; md_wd = '0; md_wreg = 1'b0;

    vecs.push_back('{"mul_7x-3",      3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33});
    vecs.push_back('{"mulh_min_m1",   3'b001, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 33});
    vecs.push_back('{"mulhsu_min_m1", 3'b010, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 33});
    vecs.push_back('{"mulhu_min_m1",  3'b011, 32'h8000_0000,  32'hFFFF_FFFF, 32'h7FFF_FFFF, 33});
    vecs.push_back('{"div_-7_2",      3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33});
    vecs.push_back('{"rem_-7_2",      3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33});
    vecs.push_back('{"divu_max_2",    3'b101, 32'hFFFF_FFFF,  32'd2,         32'h7FFF_FFFF, 33});
    vecs.push_back('{"remu_7_0",      3'b111, 32'd7,          32'd0,         32'd7,         1});
    vecs.push_back('{"div_5_0",       3'b100, 32'd5,          32'd0,         32'hFFFF_FFFF, 1});
    vecs.push_back('{"div_ovf",       3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1});
    vecs.push_back('{"rem_ovf",       3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1});
    vecs.push_back('{"divu_x_0",      3'b101, 32'h1234_5678,  32'd0,         32'hFFFF_FFFF, 1});
    vecs.push_back('{"rem_7_-2",      3'b110, 32'd7,          32'hFFFF_FFFE, 32'd1,         33});
    vecs.push_back('{"mulhu_max_max", 3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33});

    // Reset state before any clock edge is seen.
    #2;
    check("reset md_done",   {31'd0, md_done},   32'd0);
    check("reset md_result", md_result,          32'd0);
    check("reset md_wd_o",   {27'd0, md_wd_o},   32'd0);
    check("reset md_wreg_o", {31'd0, md_wreg_o}, 32'd0);
    check("reset stall_req", {31'd0, stall_req}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i])
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, 5'(i + 1), 1'(i % 2),
             vecs[i].exp_res, vecs[i].exp_lat);

    // Flush wins over start in IDLE: no stall, no result.
    @(negedge clk);
    md_start = 1'b1; md_flush = 1'b1; md_op = 3'b000; md_reg1 = 32'd3; md_reg2 = 32'd4;
    #1;
    check("flush_vs_start stall", {31'd0, stall_req}, 32'd0);
    @(negedge clk);
    md_start = 1'b0; md_flush = 1'b0;
    #1;
    check("flush_vs_start done", {31'd0, md_done}, 32'd0);

    // Flush in BUSY at T+10: idle at T+11 and no md_done afterwards.
    @(negedge clk);
    md_start = 1'b1; md_op = 3'b000; md_reg1 = 32'd11; md_reg2 = 32'd13; md_wd = 5'd3;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      md_start = 1'b0;
      if (c == 10) md_flush = 1'b1;
    end
    @(negedge clk);
    md_flush = 1'b0;
    #1;
    check("flush_busy stall_t11", {31'd0, stall_req}, 32'd0);
    check("flush_busy done_t11",  {31'd0, md_done},   32'd0);
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk); #1;
      if (md_done || stall_req) seen++;
    end
    check("flush_busy quiet_after", 32'(seen), 32'd0);
    run_op("after_flush_mul", 3'b000, 32'd1000, 32'hFFFF_FFF6, 5'd21, 1'b1, 32'hFFFF_D8F0, 33);

    // Asynchronous reset mid-BUSY, between clock edges.
    run_op("pre_reset_mulhu", 3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 1'b1,
           32'h7FFF_FFFF, 33);
    @(negedge clk);
    md_start = 1'b1; md_op = 3'b001; md_reg1 = 32'h7000_0000; md_reg2 = 32'h7000_0000;
    @(negedge clk);
    md_start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_rst md_done",   {31'd0, md_done},   32'd0);
    check("async_rst md_result", md_result,          32'd0);
    check("async_rst md_wd_o",   {27'd0, md_wd_o},   32'd0);
    check("async_rst md_wreg_o", {31'd0, md_wreg_o}, 32'd0);
    check("async_rst stall_req", {31'd0, stall_req}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    for (int c = 0; c < 35; c++) begin
      @(negedge clk); #1;
      if (md_done || stall_req) seen++;
    end
    check("async_rst no_partial", 32'(seen), 32'd0);
    run_op("post_reset_divu", 3'b101, 32'd100, 32'd7, 5'd17, 1'b1, 32'd14, 33);

    // Random ops against the reference model.
    for (int i = 0; i < 50; i++) begin
      rop = 3'($urandom);
      case ($urandom_range(0, 5))
        0:       ra = 32'h8000_0000;
        1:       ra = 32'($urandom_range(0, 20)) - 32'd10;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'($urandom_range(1, 9));
        default: rb = $urandom;
      endcase
      run_op($sformatf("rand%0d op%0d a=%08h b=%08h", i, rop, ra, rb), rop, ra, rb,
             5'($urandom), 1'($urandom), ref_result(rop, ra, rb), ref_latency(rop, ra, rb));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative RV32M multiply/divide unit in the execute stage, fed directly by the ID/EX pipeline register outputs. Accepts one M-extension operation at a time, asserts a stall request toward the pipeline control while it iterates, and presents a registered 32-bit result with its writeback address for one cycle to the EX/MEM register. Single-issue, not pipelined internally; flushable.

## Interface
- `XLEN`, 32: operand/result width; only 32 is supported.
- `clk` input, 1: core clock.
- `rst` input, 1: asynchronous, active-low reset (asserted when 0).
- `md_start` input, 1: EX holds a valid M-extension op this cycle.
- `md_op` input, 3: RV32M funct3. 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `md_reg1` input, 32: rs1 operand (multiplicand/dividend).
- `md_reg2` input, 32: rs2 operand (multiplier/divisor).
- `md_wd` input, 5: destination register address.
- `md_wreg` input, 1: write enable accompanying the op.
- `md_flush` input, 1: abort any in-flight op (branch/exception).
- `stall_req` output, 1: hold IF, ID and ID/EX.
- `md_done` output, 1: result valid this cycle.
- `md_result` output, 32: result.
- `md_wd_o` output, 5: latched destination address.
- `md_wreg_o` output, 1: latched write enable, qualified by `md_done`.

## Operation
- States: IDLE, BUSY, DONE. Reset → IDLE. Reset values: `md_done`=0, `md_result`=0, `md_wd_o`=0, `md_wreg_o`=0, iteration counter 0; `stall_req`=0 because it is decoded from state.
- IDLE, `md_start`=1, `md_flush`=0: latch op, wd, wreg, operand signs, and absolute values. Signed ops use abs(); unsigned ops use raw values. MULHSU treats only rs1 as signed.
- Normal path: IDLE → BUSY, counter=0.
- Division fast paths: IDLE → DONE directly.
  - Divisor 0: DIV/DIVU quotient 0xFFFFFFFF; REM/REMU remainder = rs1.
  - DIV/REM with rs1=0x80000000 and rs2=0xFFFFFFFF: quotient 0x80000000, remainder 0.
- BUSY multiply: one shift-add step per cycle on unsigned magnitudes, 64-bit accumulator.
- BUSY divide: one restoring step per cycle, 32-bit quotient and 33-bit partial remainder.
- After counter reaches 31: BUSY → DONE. Sign fix-up and result selection happen on that transition edge.
  - Negate the 64-bit product if operand signs differ (signed ops only).
  - Negate the quotient if signs differ (DIV).
  - Remainder takes the dividend's sign (REM).
  - Select output: MUL low 32 bits; MULH/MULHSU/MULHU high 32 bits.
- DONE: `md_done`=1 for exactly one cycle, then DONE → IDLE unconditionally. `md_start` is ignored in DONE because the retiring instruction is still visible at the inputs.
- `stall_req` = (IDLE & `md_start` & !`md_flush`) | BUSY.
- `md_flush`: in any state, next state IDLE and `md_done` forced 0 next cycle; the op is discarded. Flush takes priority over start.
- Reset mid-operation: immediate return to reset values; no partial result is emitted.

## Timing
- Start sampled in cycle T.
- Normal path: `stall_req` high cycles T..T+32 (33 cycles); `md_done`, `md_result`, `md_wd_o` and `md_wreg_o` valid in cycle T+33. Latency 33 cycles, throughput one op per 34 cycles.
- Fast path: `stall_req` high in cycle T only; `md_done` high in T+1.
- A back-to-back M op is presented in T+34 (IDLE) and sampled then.
- `md_result`, `md_wd_o` and `md_wreg_o` hold their last value outside DONE; consumers qualify with `md_done`.
- `stall_req` is combinational from registered state and inputs; no other combinational input-to-output paths.

## Test plan
- MUL 7 × -3 (rs2=0xFFFFFFFD) → `md_result`=0xFFFFFFEB in T+33; `stall_req` high exactly 33 cycles.
- MULH/MULHSU/MULHU with rs1=0x80000000, rs2=0xFFFFFFFF → 0x00000000 / 0x80000000 / 0x7FFFFFFF.
- DIV -7/2 → 0xFFFFFFFD; REM -7/2 → 0xFFFFFFFF; DIVU 0xFFFFFFFF/2 → 0x7FFFFFFF; REMU 7/0 → 7.
- DIV 5/0 → 0xFFFFFFFF and DIV 0x80000000/-1 → 0x80000000, both with `md_done` in T+1 and one stall cycle.
- Flush in BUSY at T+10 → IDLE at T+11, no `md_done`, `stall_req` low; the next op then completes correctly.
- `rst` pulled low mid-BUSY (async, between edges) → all outputs 0 immediately; after release, a DIVU 100/7 yields 14 with correct `md_wd_o`/`md_wreg_o`.
